// File: rtl/branch_predictor_gshare.sv
// ============================================================================
// branch_predictor_gshare
//
// Front-end next-PC predictor built from three structures:
//   - a direct-mapped BTB (valid, tag, target, kind) that identifies control
//     flow instructions and supplies their last taken target,
//   - a PHT of 2-bit saturating counters, indexed either by PC alone
//     (bimodal) or by PC XOR global history (gshare),
//   - a small circular return-address stack used for returns.
//
// Prediction is purely combinational from fetch_pc and the current state.
// All updates happen at the clock edge. A same-cycle read of an entry that
// is being written therefore returns the old contents.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   fetch_pc        PC being fetched this cycle
//   predict_taken   fetch PC is predicted to redirect
//   predict_target  predicted next PC
//   predict_ghr     history snapshot, carried down the pipe to update_ghr
//   btb_hit         valid BTB entry whose tag matches fetch_pc
//   update_*        resolved control-flow instruction from the back end
// ============================================================================
module branch_predictor_gshare #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int PHT_ENTRIES = 64,
    parameter int GHR_BITS    = 6,
    parameter int RAS_DEPTH   = 4,
    parameter int MODE        = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     fetch_pc,
    output logic                predict_taken,
    output logic [XLEN-1:0]     predict_target,
    output logic [GHR_BITS-1:0] predict_ghr,
    output logic                btb_hit,
    input  logic                update_en,
    input  logic [XLEN-1:0]     update_pc,
    input  logic [1:0]          update_kind,
    input  logic                update_taken,
    input  logic [XLEN-1:0]     update_target,
    input  logic                update_is_call,
    input  logic [GHR_BITS-1:0] update_ghr
);

    localparam int BTB_IDX = $clog2(BTB_ENTRIES);
    localparam int PHT_IDX = $clog2(PHT_ENTRIES);
    localparam int RAS_IDX = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int TAG_W   = XLEN - BTB_IDX - 2;
    localparam logic [RAS_IDX:0] RAS_FULL = (RAS_IDX + 1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        KIND_COND = 2'd0,
        KIND_JAL  = 2'd1,
        KIND_JALR = 2'd2,
        KIND_RET  = 2'd3
    } kind_t;

    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]     btb_target [BTB_ENTRIES];
    kind_t               btb_kind   [BTB_ENTRIES];
    logic [1:0]          pht        [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [XLEN-1:0]     ras        [RAS_DEPTH];
    logic [RAS_IDX-1:0]  ras_ptr;
    logic [RAS_IDX:0]    ras_count;

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [BTB_IDX-1:0] fetch_btb_idx;
    logic [TAG_W-1:0]   fetch_tag;
    logic [PHT_IDX-1:0] fetch_hist;
    logic [PHT_IDX-1:0] fetch_pht_idx;
    kind_t              fetch_kind;
    logic [XLEN-1:0]    ras_top;
    logic               ras_empty;

    assign fetch_btb_idx = fetch_pc[BTB_IDX+1:2];
    assign fetch_tag     = fetch_pc[XLEN-1:BTB_IDX+2];
    // History is zero-extended up to the PHT index width before the XOR
    assign fetch_hist    = (MODE == 1) ? PHT_IDX'(ghr) : '0;
    assign fetch_pht_idx = fetch_pc[PHT_IDX+1:2] ^ fetch_hist;
    assign fetch_kind    = btb_kind[fetch_btb_idx];

    // ras_ptr names the next free slot, so the top lives one below it
    assign ras_top   = ras[ras_ptr - 1'b1];
    assign ras_empty = (ras_count == '0);

    assign btb_hit       = btb_valid[fetch_btb_idx] && (btb_tag[fetch_btb_idx] == fetch_tag);
    assign predict_taken = btb_hit && ((fetch_kind != KIND_COND) || pht[fetch_pht_idx][1]);
    assign predict_ghr   = ghr;

    always_comb begin
        predict_target = fetch_pc + XLEN'(4);
        if (predict_taken) begin
            if ((fetch_kind == KIND_RET) && !ras_empty) begin
                predict_target = ras_top;
            end else begin
                predict_target = btb_target[fetch_btb_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Update-side decode
    // ------------------------------------------------------------------
    logic [BTB_IDX-1:0] upd_btb_idx;
    logic [PHT_IDX-1:0] upd_hist;
    logic [PHT_IDX-1:0] upd_pht_idx;
    logic [1:0]         upd_ctr;
    logic [1:0]         upd_ctr_next;
    logic               upd_is_cond;
    logic               upd_is_ret;
    logic               ras_wr_en;
    logic [RAS_IDX-1:0] ras_wr_idx;

    assign upd_btb_idx = update_pc[BTB_IDX+1:2];
    // The PHT entry trained is the one the instruction read at fetch, so the
    // history comes from the carried snapshot rather than the live GHR
    assign upd_hist    = (MODE == 1) ? PHT_IDX'(update_ghr) : '0;
    assign upd_pht_idx = update_pc[PHT_IDX+1:2] ^ upd_hist;
    assign upd_ctr     = pht[upd_pht_idx];
    assign upd_is_cond = (update_kind == KIND_COND);
    assign upd_is_ret  = (update_kind == KIND_RET);

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (update_taken && (upd_ctr != 2'b11)) begin
            upd_ctr_next = upd_ctr + 2'b01;
        end else if (!update_taken && (upd_ctr != 2'b00)) begin
            upd_ctr_next = upd_ctr - 2'b01;
        end
    end

    // A call that is also a return overwrites the top in place instead of
    // pushing a fresh slot
    assign ras_wr_en  = update_en && update_is_call;
    assign ras_wr_idx = upd_is_ret ? (ras_ptr - 1'b1) : ras_ptr;

    // ------------------------------------------------------------------
    // Control state: valid bits, counters, history and RAS bookkeeping.
    // Reset wins over any update presented in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
            ghr       <= '0;
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (update_en) begin
            if (update_taken) begin
                btb_valid[upd_btb_idx] <= 1'b1;
            end
            if (upd_is_cond) begin
                pht[upd_pht_idx] <= upd_ctr_next;
                // Cast drops the oldest bit of the shifted history
                ghr <= GHR_BITS'({update_ghr, update_taken});
            end
            if (update_is_call && !upd_is_ret) begin
                ras_ptr <= ras_ptr + 1'b1;
                if (ras_count != RAS_FULL) begin
                    ras_count <= ras_count + 1'b1;
                end
            end else if (upd_is_ret && !update_is_call && !ras_empty) begin
                ras_ptr   <= ras_ptr - 1'b1;
                ras_count <= ras_count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload storage with no reset: BTB tag/target/kind and RAS data are
    // only ever observed behind a valid bit or a non-zero RAS count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (update_en && update_taken) begin
            btb_tag[upd_btb_idx]    <= update_pc[XLEN-1:BTB_IDX+2];
            btb_target[upd_btb_idx] <= update_target;
            btb_kind[upd_btb_idx]   <= kind_t'(update_kind);
        end
        if (ras_wr_en) begin
            ras[ras_wr_idx] <= update_pc + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// ============================================================================
// tb_branch_predictor_gshare
//
// Two predictor instances share every input: the default gshare build and a
// bimodal build. The bimodal copy exercises counter training on one PC
// without history getting in the way; the gshare copy runs a table of
// directed vectors covering reset, history indexing, BTB allocation and
// aliasing, and return-address stack behaviour.
//
// Each vector is driven just after a rising edge, its expected outputs are
// compared on the following falling edge (state as it stood before that
// vector's update), and the vector's update then lands on the next rise.
// ============================================================================
module tb_branch_predictor_gshare;

    localparam logic [1:0] K_COND = 2'd0;
    localparam logic [1:0] K_JAL  = 2'd1;
    localparam logic [1:0] K_RET  = 2'd3;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic [1:0]  update_kind;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_is_call;
    logic [5:0]  update_ghr;

    logic        predict_taken;
    logic [31:0] predict_target;
    logic [5:0]  predict_ghr;
    logic        btb_hit;

    logic        bi_predict_taken;
    logic [31:0] bi_predict_target;
    logic [5:0]  bi_predict_ghr;
    logic        bi_btb_hit;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic [31:0] fpc;
        logic        en;
        logic [1:0]  kind;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic        call;
        logic [5:0]  ughr;
        logic        chk;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [5:0]  e_ghr;
        logic        e_hit;
    } vec_t;

    vec_t vecs[$];

    branch_predictor_gshare #(.MODE(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .predict_ghr    (predict_ghr),
        .btb_hit        (btb_hit),
        .update_en      (update_en),
        .update_pc      (update_pc),
        .update_kind    (update_kind),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_is_call (update_is_call),
        .update_ghr     (update_ghr)
    );

    branch_predictor_gshare #(.MODE(0)) dut_bi (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .predict_taken  (bi_predict_taken),
        .predict_target (bi_predict_target),
        .predict_ghr    (bi_predict_ghr),
        .btb_hit        (bi_btb_hit),
        .update_en      (update_en),
        .update_pc      (update_pc),
        .update_kind    (update_kind),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_is_call (update_is_call),
        .update_ghr     (update_ghr)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic [31:0] fpc,
                                input logic en, input logic [1:0] kind,
                                input logic [31:0] upc, input logic tk,
                                input logic [31:0] tgt, input logic call,
                                input logic [5:0] ughr, input logic chk,
                                input logic e_tk, input logic [31:0] e_tgt,
                                input logic [5:0] e_ghr, input logic e_hit);
        vec_t v;
        v.rst = r;     v.fpc = fpc;   v.en = en;       v.kind = kind;
        v.upc = upc;   v.tk = tk;     v.tgt = tgt;     v.call = call;
        v.ughr = ughr; v.chk = chk;   v.e_tk = e_tk;   v.e_tgt = e_tgt;
        v.e_ghr = e_ghr; v.e_hit = e_hit;
        return v;
    endfunction

    // Fetch-only vector with an expected prediction
    function automatic vec_t fo(input logic [31:0] fpc, input logic e_tk,
                                input logic [31:0] e_tgt, input logic [5:0] e_ghr,
                                input logic e_hit);
        return mk(1'b0, fpc, 1'b0, K_COND, 32'h0, 1'b0, 32'h0, 1'b0, 6'h0,
                  1'b1, e_tk, e_tgt, e_ghr, e_hit);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        fetch_pc       = v.fpc;
        update_en      = v.en;
        update_kind    = v.kind;
        update_pc      = v.upc;
        update_taken   = v.tk;
        update_target  = v.tgt;
        update_is_call = v.call;
        update_ghr     = v.ughr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus(mk(1'b1, 32'h0, 1'b0, K_COND, 32'h0, 1'b0, 32'h0, 1'b0,
                         6'h0, 1'b0, 1'b0, 32'h0, 6'h0, 1'b0));
        tick();

        // ---------------- Bimodal counter training on 0x200 ----------------
        applyStimulus(mk(1'b0, 32'h200, 1'b1, K_COND, 32'h200, 1'b1, 32'h180,
                         1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 6'h0, 1'b0));
        tick();
        update_en = 1'b0;
        @(negedge clk);
        checkOutput("bi_train1_hit",    32'(bi_btb_hit),       32'h1);
        checkOutput("bi_train1_taken",  32'(bi_predict_taken), 32'h1);
        checkOutput("bi_train1_target", bi_predict_target,     32'h180);
        tick();

        // Three not-taken: 2 -> 1 -> 0 -> 0 (floor)
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(1'b0, 32'h200, 1'b1, K_COND, 32'h200, 1'b0, 32'h204,
                             1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 6'h0, 1'b0));
            tick();
        end
        update_en = 1'b0;
        @(negedge clk);
        checkOutput("bi_nt3_hit",    32'(bi_btb_hit),       32'h1);
        checkOutput("bi_nt3_taken",  32'(bi_predict_taken), 32'h0);
        checkOutput("bi_nt3_target", bi_predict_target,     32'h204);
        tick();

        // Four taken saturate at 3; one not-taken leaves 2, still taken
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(1'b0, 32'h200, 1'b1, K_COND, 32'h200, (i < 4),
                             32'h180, 1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 6'h0, 1'b0));
            tick();
        end
        update_en = 1'b0;
        @(negedge clk);
        checkOutput("bi_sat_taken",  32'(bi_predict_taken), 32'h1);
        checkOutput("bi_sat_target", bi_predict_target,     32'h180);
        checkOutput("bi_sat_ghr",    32'(bi_predict_ghr),   32'h0);
        tick();

        // ---------------- Gshare vector table ----------------
        // Reset, then empty-BTB prediction
        vecs.push_back(mk(1, 32'h100, 0, K_COND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(fo(32'h100, 0, 32'h104, 0, 0));
        // update_en low must not allocate
        vecs.push_back(mk(0, 32'h200, 0, K_COND, 32'h200, 1, 32'h180, 0, 0, 1, 0, 32'h204, 0, 0));
        // Reset beats a simultaneous taken update
        vecs.push_back(mk(1, 32'h200, 1, K_COND, 32'h200, 1, 32'h180, 0, 0, 1, 0, 32'h204, 0, 0));
        vecs.push_back(fo(32'h200, 0, 32'h204, 0, 0));
        // Gshare indexing: BTB entries at 0x50/0x5C, then train index 16^3=19
        vecs.push_back(mk(0, 32'h50, 1, K_COND, 32'h50, 1, 32'h500, 0, 0, 1, 0, 32'h54, 0, 0));
        vecs.push_back(mk(0, 32'h50, 1, K_COND, 32'h5C, 1, 32'h600, 0, 0, 1, 0, 32'h54, 1, 1));
        vecs.push_back(mk(0, 32'h5C, 1, K_COND, 32'h40, 1, 32'h400, 0, 6'h03, 1, 0, 32'h60, 1, 1));
        vecs.push_back(fo(32'h50, 1, 32'h500, 6'h07, 1));   // 20^7 = 19, counter 2
        vecs.push_back(fo(32'h5C, 0, 32'h60,  6'h07, 1));   // 23^7 = 16, counter 1
        vecs.push_back(fo(32'h40, 1, 32'h400, 6'h07, 1));   // 16^7 = 23, counter 2
        // Non-conditional update leaves GHR alone; 0x80 evicts 0x40
        vecs.push_back(mk(0, 32'h100, 1, K_JAL, 32'h80, 1, 32'h800, 0, 0, 1, 0, 32'h104, 7, 0));
        vecs.push_back(fo(32'h80, 1, 32'h800, 6'h07, 1));
        vecs.push_back(fo(32'h40, 0, 32'h44,  6'h07, 0));
        // Aliasing on BTB index 0
        vecs.push_back(mk(0, 32'h1000, 1, K_JAL, 32'h1000, 1, 32'h2000, 0, 0, 1, 0, 32'h1004, 7, 0));
        vecs.push_back(mk(0, 32'h1000, 1, K_JAL, 32'h1040, 1, 32'h3000, 0, 0, 1, 1, 32'h2000, 7, 1));
        vecs.push_back(fo(32'h1000, 0, 32'h1004, 6'h07, 0));
        vecs.push_back(fo(32'h1040, 1, 32'h3000, 6'h07, 1));
        // Not-taken cond keeps BTB, shifts a 0 into history
        vecs.push_back(mk(0, 32'h1040, 1, K_COND, 32'h1040, 0, 32'h9990, 0, 7, 1, 1, 32'h3000, 7, 1));
        vecs.push_back(fo(32'h1040, 1, 32'h3000, 6'h0E, 1));
        // Return entry at 0x300 installed on an empty RAS
        vecs.push_back(mk(0, 32'h300, 1, K_RET, 32'h300, 1, 32'h900, 0, 0, 1, 0, 32'h304, 14, 0));
        vecs.push_back(fo(32'h300, 1, 32'h900, 6'h0E, 1));
        // Five calls (not taken so the BTB entry at index 0 survives 0x40)
        vecs.push_back(mk(0, 32'h300, 1, K_JAL, 32'h10, 0, 0, 1, 0, 1, 1, 32'h900, 14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_JAL, 32'h20, 0, 0, 1, 0, 1, 1, 32'h14,  14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_JAL, 32'h30, 0, 0, 1, 0, 1, 1, 32'h24,  14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_JAL, 32'h40, 0, 0, 1, 0, 1, 1, 32'h34,  14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_JAL, 32'h50, 0, 0, 1, 0, 1, 1, 32'h44,  14, 1));
        // Pops: oldest 0x14 was overwritten, so the stack drains after 0x24
        vecs.push_back(mk(0, 32'h300, 1, K_RET, 32'h300, 1, 32'h900, 0, 0, 1, 1, 32'h54, 14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_RET, 32'h300, 1, 32'h900, 0, 0, 1, 1, 32'h44, 14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_RET, 32'h300, 1, 32'h900, 0, 0, 1, 1, 32'h34, 14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_RET, 32'h300, 1, 32'h900, 0, 0, 1, 1, 32'h24, 14, 1));
        vecs.push_back(fo(32'h300, 1, 32'h900, 6'h0E, 1));
        // Call+ret in one update replaces the top without moving the count
        vecs.push_back(mk(0, 32'h300, 1, K_JAL, 32'h600, 0, 0, 1, 0, 1, 1, 32'h900, 14, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_RET, 32'h300, 1, 32'h900, 1, 0, 1, 1, 32'h604, 14, 1));
        vecs.push_back(fo(32'h300, 1, 32'h304, 6'h0E, 1));
        vecs.push_back(mk(0, 32'h300, 1, K_RET, 32'h300, 1, 32'h900, 0, 0, 1, 1, 32'h304, 14, 1));
        vecs.push_back(fo(32'h300, 1, 32'h900, 6'h0E, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                checkOutput($sformatf("v%0d_taken", i),  32'(predict_taken), 32'(vecs[i].e_tk));
                checkOutput($sformatf("v%0d_target", i), predict_target,     vecs[i].e_tgt);
                checkOutput($sformatf("v%0d_ghr", i),    32'(predict_ghr),   32'(vecs[i].e_ghr));
                checkOutput($sformatf("v%0d_hit", i),    32'(btb_hit),       32'(vecs[i].e_hit));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 32, address width.
- BTB_ENTRIES, 16, direct-mapped BTB entries; power of 2, at least 2.
- PHT_ENTRIES, 64, 2-bit counter entries; power of 2.
- GHR_BITS, 6, global history length; at most log2(PHT_ENTRIES).
- RAS_DEPTH, 4, return-address stack entries; power of 2.
- MODE, 1, PHT indexing: 0 = bimodal, 1 = gshare.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- fetch_pc, in, XLEN, PC being fetched.
- predict_taken, out, 1, fetch PC predicted taken.
- predict_target, out, XLEN, next-PC prediction.
- predict_ghr, out, GHR_BITS, GHR snapshot; the pipeline carries it to update_ghr.
- btb_hit, out, 1, valid BTB entry with tag match.
- update_en, in, 1, resolved control-flow instruction this cycle.
- update_pc, in, XLEN, PC of the resolved instruction.
- update_kind, in, 2, 0 = cond, 1 = jal, 2 = jalr, 3 = ret.
- update_taken, in, 1, actual direction.
- update_target, in, XLEN, actual target.
- update_is_call, in, 1, jal/jalr with rd = x1 or x5.
- update_ghr, in, GHR_BITS, predict_ghr captured when this instruction was fetched.

Function
REQ-003 BTB index SHALL be pc[log2(BTB_ENTRIES)+1:2]; the tag SHALL be pc[XLEN-1:log2(BTB_ENTRIES)+2]; each entry SHALL hold valid, tag, target and kind.
REQ-004 PHT index SHALL be pc[log2(PHT_ENTRIES)+1:2] XOR the zero-extended GHR when MODE = 1, and pc[log2(PHT_ENTRIES)+1:2] when MODE = 0.
REQ-005 Prediction SHALL be combinational from fetch_pc and the current state, with zero-cycle latency.
REQ-006 predict_taken SHALL be btb_hit AND (kind != cond OR counter[1] = 1).
REQ-007 predict_target SHALL be selected as follows:
- RAS top when predict_taken, kind = ret and the RAS is non-empty.
- BTB target when predict_taken, otherwise.
- fetch_pc + 4 when not predict_taken.
REQ-008 predict_ghr SHALL equal the current GHR register value.
REQ-009 On update_en with update_kind = cond:
- The PHT entry indexed by update_pc and update_ghr SHALL saturate-increment when update_taken and saturate-decrement otherwise, bounded 0..3.
- GHR SHALL become {update_ghr[GHR_BITS-2:0], update_taken} on the next edge.
REQ-010 On update_en with update_kind != cond, the GHR and PHT SHALL be unchanged.
REQ-011 On update_en with update_taken = 1, the BTB entry SHALL be written (valid = 1, tag, target, kind), overwriting any previous occupant.
REQ-012 On update_en with update_taken = 0, the BTB SHALL be unchanged.
REQ-013 On update_en with update_is_call, the RAS SHALL push update_pc + 4. When the RAS is full, the push SHALL overwrite the oldest entry (circular pointer wrap) and the count SHALL stay at RAS_DEPTH.
REQ-014 On update_en with update_kind = ret:
- The RAS SHALL pop: pointer decrements, count decrements.
- Pop on an empty RAS SHALL leave the state unchanged.
REQ-015 A call and a ret in the same update SHALL replace the top entry with update_pc + 4; pointer and count SHALL be unchanged.
REQ-016 All state writes SHALL take effect at the clock edge. A same-cycle read of an index being written SHALL return the pre-write value.
REQ-017 update_en = 0 SHALL modify no state.

Reset
REQ-018 When rst is high at a clock edge, the following SHALL reset:
- all BTB valid bits to 0;
- all PHT counters to 2'b01 (weakly not-taken);
- GHR to 0;
- RAS pointer and count to 0.
REQ-019 Reset SHALL take priority over a simultaneous update_en.
REQ-020 While the BTB is empty, outputs SHALL be predict_taken = 0, btb_hit = 0, predict_target = fetch_pc + 4 and predict_ghr = 0.
REQ-021 BTB targets and RAS data need not be reset.

Verification
REQ-022 Reset, then fetch_pc = 0x100 -> predict_taken = 0, btb_hit = 0, predict_target = 0x104, predict_ghr = 0.
REQ-023 Train cond at 0x200, target 0x180:
- One update, taken -> next cycle btb_hit = 1, counter 2, predict_taken = 1, target 0x180.
- Then three updates, not-taken -> counter 0, predict_taken = 0, target 0x204.
REQ-024 MODE = 1, GHR_BITS = 6, pc 0x40 with update_ghr = 6'b000011 -> PHT index 16 XOR 3 = 19 is updated and index 16 is untouched; GHR becomes 6'b000111 after a taken update.
REQ-025 RAS_DEPTH = 4: five call updates (pc 0x10, 0x20, ..., 0x50), then a ret at 0x300 (BTB kind = ret) predicts 0x54. Four further pops predict 0x44, 0x34, 0x24, then fall back to the BTB target on the empty RAS.
REQ-026 rst asserted in the same cycle as a taken update at 0x200 -> no BTB entry is allocated; next cycle btb_hit = 0.
REQ-027 Aliasing: with BTB_ENTRIES = 16, a taken update at 0x1000 then one at 0x1040 (same index) -> fetch 0x1000 gives btb_hit = 0, fetch 0x1040 gives btb_hit = 1.
